mpu6050_seq_ctrl: RTL
=====================

// Module: mpu6050_seq_ctrl
// PURPOSE
// Transaction sequencer for I2C_master_statemachine on the MPU6050 link. Drives the master's
// 3-bit selector to wake the sensor, then periodically burst-reads the accel/temp/gyro registers
// into a shadow buffer, publishing a complete sample. Handles NACK/timeout retries and error state.
// PARAMETERS
// SAMPLE_PERIOD  20000  clk cycles between sample starts (1 ms at 20 MHz)
// NUM_BYTES      14     registers read per sample, consecutive from START_REG
// START_REG      8'h3B  first register of the burst (ACCEL_XOUT_H)
// MAX_RETRY      3      re-issues of a failed op before ERROR
// OP_TIMEOUT     4095   cycles allowed per op before it counts as failed
// PORTS
// clk          in   1            system clock (20 MHz)
// reset        in   1            asynchronous, active-low reset
// enable       in   1            1 = run sequence; 0 = return to IDLE at next op boundary
// selector     out  3            op to master: 000 idle, 001 wr ptr, 011 wr data, 100 rd ptr, 110 rd data
// reg_addr     out  8            register pointer for the current op
// wr_data      out  8            data byte for 011 ops
// master_done  in   1            one-cycle pulse: master finished current op
// master_nack  in   1            valid with master_done; 1 = slave NACK
// rd_data      in   8            byte from master, valid with master_done on 110 ops
// sample_data  out  8*NUM_BYTES  last complete sample; first byte read at MSB end
// sample_valid out  1            one-cycle pulse when sample_data updates
// busy         out  1            1 whenever state != IDLE/ERROR
// error        out  1            sticky, set in ERROR
// err_code     out  2            01 NACK exhausted, 10 timeout exhausted, 11 WHO_AM_I mismatch
// BEHAVIOUR
// - Reset (reset=0, any time, incl. mid-op): all outputs 0, state IDLE, counters/buffer cleared.
// - States: IDLE -> [WHO_PTR -> WHO_RD] -> WAKE_PTR -> WAKE_DATA -> WAIT_PERIOD -> RD_PTR ->
//   RD_DATA -> (next byte: RD_PTR | last byte: PUBLISH) -> WAIT_PERIOD ...; ERROR absorbing.
// - IDLE leaves when enable=1 (next cycle selector goes nonzero). Wake: 001 reg_addr=8'h6B, then
//   011 wr_data=8'h00.
// - Op handshake: selector/reg_addr/wr_data driven stable from issue until master_done; the cycle
//   after master_done selector=000 for exactly 1 GAP cycle before the next op is issued.
// - Read byte k (0..NUM_BYTES-1): 100 with reg_addr=START_REG+k (8-bit wrap), then 110; rd_data
//   captured into shadow slot k on master_done of the 110 op.
// - PUBLISH: shadow -> sample_data in one cycle, sample_valid=1 for that cycle only. sample_data
//   never shows a partial sample.
// - Period counter starts at entry to first RD_PTR of a sample; next sample starts when it reaches
//   SAMPLE_PERIOD-1, or immediately after PUBLISH if the burst overran the period (no skipped
//   sample queueing).
// - Failure = master_done with master_nack=1, or OP_TIMEOUT cycles with no master_done. On failure
//   the whole pair (ptr+data) is re-issued after the GAP cycle; retry count resets per pair.
//   Failure #MAX_RETRY+1 -> ERROR, error=1, err_code set, selector=000.
// - master_done while selector=000 is ignored. master_done and timeout in same cycle: done wins.
// - enable=0: current op completes (done or failure resolution), then IDLE; shadow discarded,
//   sample_data retained. ERROR is cleared (error/err_code -> 0) only by enable=0 or reset.
// CONFIGURATION
// - MPU_WHOAMI_CHECK_EN defined: before wake, 100 reg_addr=8'h75, then 110; rd_data!=8'h68 ->
//   ERROR err_code=11 (no retry); NACK/timeout retried as normal. Undefined: IDLE goes straight to
//   WAKE_PTR, err_code 11 never produced.
// TESTING
// - Reset then enable=1, master model acks with done 40 cycles after each op -> selector sequence
//   001(6B),000,011(00),000,100(3B),000,110 ...; busy=1 from first cycle after enable.
// - Full sample: model returns rd_data=8'h10+k -> one sample_valid pulse, sample_data =
//   112'h101112...1D; next sample starts SAMPLE_PERIOD cycles after first RD_PTR.
// - NACK on 110 of byte 5 twice, then ack -> 100(40),110 re-issued twice, sample completes,
//   error=0.
// - No master_done ever -> after (MAX_RETRY+1)*(OP_TIMEOUT+1) cycles: error=1, err_code=10,
//   selector=000.
// - reset=0 mid-RD_DATA -> selector, sample_valid, busy, error drop to 0 same cycle; enable=0
//   mid-op -> IDLE only after that op's done.
// - MPU_WHOAMI_CHECK_EN: rd_data=8'h68 -> proceeds to 001(6B); rd_data=8'h70 -> ERROR err_code=11.

Source files
------------

// File: rtl/mpu6050_seq_ctrl_if.sv
// Bus bundle between the MPU6050 sequencer and its surroundings.
//   master modport : the sequencer (drives selector/reg_addr/wr_data and the
//                    sample/status outputs; receives enable and the I2C master's
//                    done/nack/rd_data)
//   slave modport  : the I2C master + system side (the mirror image)
// Signals:
//   enable        run request
//   selector      op code to the I2C master (000 idle, 001 wr ptr, 011 wr data,
//                 100 rd ptr, 110 rd data)
//   reg_addr      register pointer of the current op
//   wr_data       data byte for 011 ops
//   master_done   one-cycle completion pulse from the I2C master
//   master_nack   slave NACK flag, valid with master_done
//   rd_data       read byte, valid with master_done on 110 ops
//   sample_data   last complete sample, first byte read at the MSB end
//   sample_valid  one-cycle pulse when sample_data updates
//   busy          sequencer active (not IDLE/ERROR)
//   error         sticky error flag
//   err_code      01 NACK exhausted, 10 timeout exhausted, 11 WHO_AM_I mismatch
interface mpu6050_seq_ctrl_if #(
  parameter int NUM_BYTES = 14
);
  logic                   enable;
  logic [2:0]             selector;
  logic [7:0]             reg_addr;
  logic [7:0]             wr_data;
  logic                   master_done;
  logic                   master_nack;
  logic [7:0]             rd_data;
  logic [8*NUM_BYTES-1:0] sample_data;
  logic                   sample_valid;
  logic                   busy;
  logic                   error;
  logic [1:0]             err_code;

  modport master (
    input  enable, master_done, master_nack, rd_data,
    output selector, reg_addr, wr_data, sample_data, sample_valid, busy, error, err_code
  );

  modport slave (
    output enable, master_done, master_nack, rd_data,
    input  selector, reg_addr, wr_data, sample_data, sample_valid, busy, error, err_code
  );
endinterface

// File: rtl/mpu6050_seq_ctrl.sv
// MPU6050 transaction sequencer for I2C_master_statemachine.
// Wakes the sensor (PWR_MGMT_1 <= 0x00), then every SAMPLE_PERIOD cycles
// burst-reads NUM_BYTES registers starting at START_REG into a shadow buffer
// and publishes the complete sample atomically. Failed ops (NACK or
// OP_TIMEOUT cycles without done) re-issue the whole ptr+data pair up to
// MAX_RETRY times, after which the block parks in ERROR until enable drops.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   bus    mpu6050_seq_ctrl_if.master (see interface file for signal list)
// Optional feature: define MPU_WHOAMI_CHECK_EN to read WHO_AM_I (0x75) before
// wake and stop with err_code 11 if it does not return 0x68.
module mpu6050_seq_ctrl #(
  parameter int         SAMPLE_PERIOD = 20000,
  parameter int         NUM_BYTES     = 14,
  parameter logic [7:0] START_REG     = 8'h3B,
  parameter int         MAX_RETRY     = 3,
  parameter int         OP_TIMEOUT    = 4095
) (
  input  logic               clk,
  input  logic               reset,
  mpu6050_seq_ctrl_if.master bus
);
  localparam int TMR_W = $clog2(OP_TIMEOUT + 1);
  localparam int PER_W = $clog2(SAMPLE_PERIOD + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 2);
  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [2:0] SEL_IDLE    = 3'b000;
  localparam logic [2:0] SEL_WR_PTR  = 3'b001;
  localparam logic [2:0] SEL_WR_DATA = 3'b011;
  localparam logic [2:0] SEL_RD_PTR  = 3'b100;
  localparam logic [2:0] SEL_RD_DATA = 3'b110;

  localparam logic [7:0] PWR_MGMT_1  = 8'h6B;
  localparam logic [7:0] WAKE_VALUE  = 8'h00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
`ifdef MPU_WHOAMI_CHECK_EN
  localparam logic [7:0] WHOAMI_REG  = 8'h75;
  localparam logic [7:0] WHOAMI_ID   = 8'h68;
  localparam logic [1:0] ERR_WHOAMI  = 2'b11;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_WHO_PTR, S_WHO_RD, S_WAKE_PTR, S_WAKE_DATA,
    S_WAIT_PERIOD, S_RD_PTR, S_RD_DATA, S_PUBLISH, S_ERROR
  } state_t;

  state_t                 state_q, state_d, head;
  logic                   gap_q, gap_d;
  logic [RTY_W-1:0]       retry_q, retry_d;
  logic [IDX_W-1:0]       byte_q, byte_d;
  logic [TMR_W-1:0]       timer_q;
  logic [PER_W-1:0]       period_cnt_q;
  logic                   period_run_q;
  logic [1:0]             err_code_q, err_code_d;
  logic [8*NUM_BYTES-1:0] shadow_q, sample_q;
  logic                   valid_q;

  logic       is_op, op_live, op_done, op_ok, op_fail, period_end;
  logic       period_start, capture, publish;
  logic [2:0] op_sel;
  logic [7:0] op_addr;

  assign period_end = (period_cnt_q == PER_W'(SAMPLE_PERIOD - 1));

  always_comb begin
    state_d      = state_q;
    gap_d        = 1'b0;
    retry_d      = retry_q;
    byte_d       = byte_q;
    err_code_d   = err_code_q;
    period_start = 1'b0;
    capture      = 1'b0;
    publish      = 1'b0;
    op_sel       = SEL_IDLE;
    op_addr      = 8'h00;
    is_op        = 1'b1;
    head         = state_q;

    // Op decode; head is the first op of the pair a failure re-issues.
    case (state_q)
`ifdef MPU_WHOAMI_CHECK_EN
      S_WHO_PTR:   begin op_sel = SEL_RD_PTR;  op_addr = WHOAMI_REG; head = S_WHO_PTR; end
      S_WHO_RD:    begin op_sel = SEL_RD_DATA; op_addr = WHOAMI_REG; head = S_WHO_PTR; end
`endif
      S_WAKE_PTR:  begin op_sel = SEL_WR_PTR;  op_addr = PWR_MGMT_1; head = S_WAKE_PTR; end
      S_WAKE_DATA: begin op_sel = SEL_WR_DATA; op_addr = PWR_MGMT_1; head = S_WAKE_PTR; end
      S_RD_PTR:    begin op_sel = SEL_RD_PTR;  op_addr = START_REG + 8'(byte_q); head = S_RD_PTR; end
      S_RD_DATA:   begin op_sel = SEL_RD_DATA; op_addr = START_REG + 8'(byte_q); head = S_RD_PTR; end
      default:     is_op = 1'b0;
    endcase

    // done is only honoured while an op is on the bus; done beats timeout.
    op_live = is_op && !gap_q;
    op_done = op_live && bus.master_done;
    op_ok   = op_done && !bus.master_nack;
    op_fail = op_live && (bus.master_done ? bus.master_nack
                                          : (timer_q == TMR_W'(OP_TIMEOUT - 1)));

    case (state_q)
      S_IDLE: begin
        retry_d    = '0;
        byte_d     = '0;
        err_code_d = 2'b00;
        if (bus.enable) begin
`ifdef MPU_WHOAMI_CHECK_EN
          state_d = S_WHO_PTR;
`else
          state_d = S_WAKE_PTR;
`endif
        end
      end
      S_WAIT_PERIOD: begin
        // First sample after wake starts at once; later ones on period expiry.
        if (!bus.enable) state_d = S_IDLE;
        else if (!period_run_q || period_end) begin
          state_d      = S_RD_PTR;
          period_start = 1'b1;
        end
      end
      S_PUBLISH: begin
        publish = 1'b1;
        if (!bus.enable) state_d = S_IDLE;
        else if (period_end) begin
          // Burst overran the period: start the next one straight away.
          state_d      = S_RD_PTR;
          period_start = 1'b1;
        end else state_d = S_WAIT_PERIOD;
      end
      S_ERROR: begin
        if (!bus.enable) begin
          state_d    = S_IDLE;
          err_code_d = 2'b00;
        end
      end
      default: begin
        if (gap_q) begin
          if (!bus.enable) state_d = S_IDLE;
        end else if (op_fail) begin
          if (!bus.enable) state_d = S_IDLE;
          else if (retry_q == RTY_W'(MAX_RETRY)) begin
            state_d    = S_ERROR;
            err_code_d = bus.master_done ? ERR_NACK : ERR_TIMEOUT;
          end else begin
            state_d = head;
            gap_d   = 1'b1;
            retry_d = retry_q + 1'b1;
          end
        end else if (op_ok) begin
          if (!bus.enable) state_d = S_IDLE;
          else begin
            gap_d = 1'b1;
            case (state_q)
              S_WHO_PTR: state_d = S_WHO_RD;
              S_WHO_RD: begin
                retry_d = '0;
                state_d = S_WAKE_PTR;
`ifdef MPU_WHOAMI_CHECK_EN
                if (bus.rd_data != WHOAMI_ID) begin
                  state_d    = S_ERROR;
                  err_code_d = ERR_WHOAMI;
                  gap_d      = 1'b0;
                end
`endif
              end
              S_WAKE_PTR: state_d = S_WAKE_DATA;
              S_WAKE_DATA: begin
                // WAIT_PERIOD itself provides the idle cycle after wake.
                retry_d = '0;
                gap_d   = 1'b0;
                state_d = S_WAIT_PERIOD;
              end
              S_RD_PTR: state_d = S_RD_DATA;
              S_RD_DATA: begin
                capture = 1'b1;
                retry_d = '0;
                if (byte_q == IDX_W'(NUM_BYTES - 1)) begin
                  byte_d  = '0;
                  gap_d   = 1'b0;
                  state_d = S_PUBLISH;
                end else begin
                  byte_d  = byte_q + 1'b1;
                  state_d = S_RD_PTR;
                end
              end
              default: state_d = S_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      gap_q        <= 1'b0;
      retry_q      <= '0;
      byte_q       <= '0;
      timer_q      <= '0;
      period_cnt_q <= '0;
      period_run_q <= 1'b0;
      err_code_q   <= 2'b00;
      shadow_q     <= '0;
      sample_q     <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      retry_q    <= retry_d;
      byte_q     <= byte_d;
      err_code_q <= err_code_d;
      timer_q    <= (op_live && !op_done && !op_fail) ? timer_q + 1'b1 : '0;

      // Period counter saturates at SAMPLE_PERIOD-1 so an overrun is remembered.
      if (period_start) begin
        period_cnt_q <= '0;
        period_run_q <= 1'b1;
      end else begin
        if (period_run_q && !period_end) period_cnt_q <= period_cnt_q + 1'b1;
        if (state_q == S_IDLE) period_run_q <= 1'b0;
      end

      if (state_q == S_IDLE) shadow_q <= '0;
      else if (capture) shadow_q[8*(NUM_BYTES - 1 - int'(byte_q)) +: 8] <= bus.rd_data;

      valid_q <= publish;
      if (publish) sample_q <= shadow_q;
    end
  end

  assign bus.selector     = op_live ? op_sel : SEL_IDLE;
  assign bus.reg_addr     = op_live ? op_addr : 8'h00;
  assign bus.wr_data      = WAKE_VALUE;  // the only byte ever written
  assign bus.sample_data  = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.busy         = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign bus.error        = (state_q == S_ERROR);
  assign bus.err_code     = err_code_q;
endmodule
